// File: rtl/tmds_pkg.sv
// tmds_pkg: mode encoding, fixed code tables and small helpers shared by the
// TMDS lane encoder. Build option TMDS_TERC4_EN adds the TERC4 data-island table.
package tmds_pkg;

    typedef enum logic [2:0] {
        TMDS_CTRL   = 3'd0,
        TMDS_VIDEO  = 3'd1,
        TMDS_ISLAND = 3'd2,
        TMDS_VGUARD = 3'd3,
        TMDS_DGUARD = 3'd4
    } tmds_mode_e;

    // Control symbols indexed by {C1,C0}; entry 0 is also the reset symbol.
    localparam logic [3:0][9:0] CTRL_CODES = {
        10'b1010101011,
        10'b0101010100,
        10'b0010101011,
        10'b1101010100
    };

    // Video leading guard on lanes 0 and 2.
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    // Video leading guard on lane 1 and data-island guard on lanes 1 and 2.
    localparam logic [9:0] GUARD_B = 10'b0100110011;

`ifdef TMDS_TERC4_EN
    // TERC4 symbols indexed by the data-island nibble.
    localparam logic [15:0][9:0] TERC4_TABLE = {
        10'b1011000011,
        10'b0101100011,
        10'b1001110001,
        10'b1010001110,
        10'b1011000110,
        10'b0110011100,
        10'b0100111001,
        10'b1011001100,
        10'b0100111100,
        10'b0110001110,
        10'b0100011110,
        10'b0101110001,
        10'b1011100010,
        10'b1011100100,
        10'b1001100011,
        10'b1010011100
    };
`endif

    // Number of ones in a byte.
    function automatic logic [3:0] n1_count(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Map the raw mode input onto the enum; the unused codes 5..7 behave as CTRL.
    function automatic tmds_mode_e decode_mode(input logic [2:0] m);
        tmds_mode_e r;
        case (m)
            3'd1:    r = TMDS_VIDEO;
            3'd2:    r = TMDS_ISLAND;
            3'd3:    r = TMDS_VGUARD;
            3'd4:    r = TMDS_DGUARD;
            default: r = TMDS_CTRL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: first pipeline stage of the TMDS lane. Performs transition
// minimisation of the video byte and registers it together with the side-band
// inputs so the second stage sees one coherent pixel.
module tmds_qm_stage
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_stb,
    input  logic [2:0] mode,
    input  logic [7:0] d,
    input  logic [1:0] c,
    input  logic [3:0] terc4,
    output tmds_mode_e mode_s1,
    output logic [1:0] c_s1,
    output logic [3:0] terc4_s1,
    output logic [8:0] qm_s1,
    output logic [3:0] n1_s1
);

    logic [8:0] qm;

    // Build q_m with an XOR or XNOR chain, whichever yields fewer transitions.
    always_comb begin
        logic [3:0] n1_d;
        logic       use_xnor;
        logic [7:0] chain;
        n1_d     = n1_count(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        chain    = '0;
        chain[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ d[i]) : (chain[i-1] ^ d[i]);
        end
        qm = {~use_xnor, chain};
    end

    // Capture the pixel on each strobe; reset leaves a CTRL 00 symbol in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1  <= TMDS_CTRL;
            c_s1     <= '0;
            terc4_s1 <= '0;
            qm_s1    <= '0;
            n1_s1    <= '0;
        end else if (pixel_stb) begin
            mode_s1  <= decode_mode(mode);
            c_s1     <= c;
            terc4_s1 <= terc4;
            qm_s1    <= qm;
            n1_s1    <= n1_count(qm[7:0]);
        end
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: one HDMI TMDS lane. Stage 1 (tmds_qm_stage) does
// transition minimisation; stage 2 here applies DC balancing and selects the
// symbol for the current mode. Build option TMDS_TERC4_EN enables data-island
// (TERC4) and data-island guard symbols; without it those modes send CTRL codes.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int DISP_W  = 5
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pixel_stb,
    input  logic [2:0]               mode,
    input  logic [7:0]               d,
    input  logic [1:0]               c,
    input  logic [3:0]               terc4,
    output logic [9:0]               q_out,
    output logic signed [DISP_W-1:0] disparity
);

    localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);
    localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);

    tmds_mode_e mode_s1;
    logic [1:0] c_s1;
    logic [3:0] terc4_s1;
    logic [8:0] qm_s1;
    logic [3:0] n1_s1;

    logic signed [DISP_W-1:0] n1_w;
    logic signed [DISP_W-1:0] diff_w;
    logic signed [DISP_W-1:0] disp_next;
    logic [9:0]               q_next;

    tmds_qm_stage u_qm_stage (
        .clk       (clk),
        .rst       (rst),
        .pixel_stb (pixel_stb),
        .mode      (mode),
        .d         (d),
        .c         (c),
        .terc4     (terc4),
        .mode_s1   (mode_s1),
        .c_s1      (c_s1),
        .terc4_s1  (terc4_s1),
        .qm_s1     (qm_s1),
        .n1_s1     (n1_s1)
    );

`ifndef TMDS_TERC4_EN
    logic unused_terc4;
    assign unused_terc4 = ^terc4_s1;
`endif

    // Select the output symbol for the staged mode and work out the next running disparity.
    always_comb begin
        n1_w      = DISP_W'(n1_s1);
        diff_w    = n1_w - (EIGHT - n1_w);
        q_next    = CTRL_CODES[c_s1];
        disp_next = '0;
        case (mode_s1)
            TMDS_VIDEO: begin
                if ((disparity == '0) || (n1_s1 == 4'd4)) begin
                    q_next    = {~qm_s1[8], qm_s1[8], qm_s1[8] ? qm_s1[7:0] : ~qm_s1[7:0]};
                    disp_next = qm_s1[8] ? (disparity + diff_w) : (disparity - diff_w);
                end else if (((disparity > 0) && (n1_s1 > 4'd4)) ||
                             ((disparity < 0) && (n1_s1 < 4'd4))) begin
                    q_next    = {1'b1, qm_s1[8], ~qm_s1[7:0]};
                    disp_next = disparity - diff_w + (qm_s1[8] ? TWO : '0);
                end else begin
                    q_next    = {1'b0, qm_s1[8], qm_s1[7:0]};
                    disp_next = disparity + diff_w - (qm_s1[8] ? '0 : TWO);
                end
            end
            TMDS_VGUARD: begin
                q_next = (CHANNEL == 1) ? GUARD_B : GUARD_A;
            end
`ifdef TMDS_TERC4_EN
            TMDS_ISLAND: begin
                q_next = TERC4_TABLE[terc4_s1];
            end
            TMDS_DGUARD: begin
                q_next = (CHANNEL == 0) ? TERC4_TABLE[{2'b11, c_s1}] : GUARD_B;
            end
`endif
            default: begin
                q_next = CTRL_CODES[c_s1];
            end
        endcase
    end

    // Stage 2: register the symbol and disparity on each strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_out     <= CTRL_CODES[0];
            disparity <= '0;
        end else if (pixel_stb) begin
            q_out     <= q_next;
            disparity <= disp_next;
        end
    end

endmodule
